axi_lite_master: RTL and testbench

//  Single-outstanding AXI-lite initiator bridging a simple CPU memory request port (IFU/LSU) onto the ar/r/aw/w/b channels of sim_sram-style slaves.

---
 rtl/axi_lite_master.sv | 200 ++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: turns one CPU read/write request into
// AR/R or AW/W/B traffic and returns a one-cycle completion pulse.
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              is_wr_q;
    logic              aw_done;
    logic              w_done;

    logic req_fire;
    logic aw_fire;
    logic w_fire;
    logic r_fire;
    logic b_fire;

    assign req_fire = req_valid & req_ready;
    assign aw_fire  = awvalid & awready;
    assign w_fire   = wvalid & wready;
    assign r_fire   = rvalid & rready;
    assign b_fire   = bvalid & bready;

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are frozen at accept so the CPU may change req_* freely afterwards.
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
            is_wr_q <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                is_wr_q <= req_wen;
                rdata_q <= '0;
                resp_q  <= 2'b00;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_fire) begin
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                w_done <= 1'b1;
            end
            if (r_fire) begin
                rdata_q <= rdata;
                resp_q  <= rresp;
            end
            if (b_fire) begin
                resp_q <= bresp;
            end
        end
    end

    // AW and W may complete in either order or together; a pending channel counts
    // as done in the cycle its ready arrives.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_wen ? WR_AW_W : RD_AR;
                end
            end
            RD_AR: begin
                if (arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                if (rvalid) begin
                    state_next = RESP;
                end
            end
            WR_AW_W: begin
                if ((aw_done | awready) & (w_done | wready)) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                if (bvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            RD_AR: begin
                arvalid = 1'b1;
            end
            RD_R: begin
                rready = 1'b1;
            end
            WR_AW_W: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
            end
            WR_B: begin
                bready = 1'b1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = is_wr_q ? '0 : rdata_q;
                resp_err   = (resp_q != 2'b00);
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable AXI-lite slave plus a
// transaction-level model of expected latency, data, error and channel activity.
module tb_axi_lite_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam int AR_HS = 0;
    localparam int R_HS  = 1;
    localparam int AW_HS = 2;
    localparam int W_HS  = 3;
    localparam int B_HS  = 4;
    localparam int ARV   = 5;
    localparam int RRDY  = 6;
    localparam int AWV   = 7;
    localparam int WV    = 8;
    localparam int BRDY  = 9;
    localparam int N_CNT = 10;

    typedef struct {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] slv_rdata;
        logic [1:0]        slv_resp;
        int                ar_d;
        int                r_d;
        int                aw_d;
        int                w_d;
        int                b_d;
        int                exp_lat;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_wen = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [STRB_W-1:0] req_wstrb = '0;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              bready;

    logic              s_arready = 1'b0;
    logic              s_rvalid = 1'b0;
    logic [DATA_W-1:0] s_rdata = '0;
    logic [1:0]        s_rresp = 2'b00;
    logic              s_awready = 1'b0;
    logic              s_wready = 1'b0;
    logic              s_bvalid = 1'b0;
    logic [1:0]        s_bresp = 2'b00;
    logic              stray = 1'b0;
    logic              slave_en = 1'b1;

    logic              arready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              awready;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;

    assign arready = s_arready;
    assign rvalid  = s_rvalid | stray;
    assign rdata   = s_rdata;
    assign rresp   = stray ? 2'b10 : s_rresp;
    assign awready = s_awready;
    assign wready  = s_wready;
    assign bvalid  = s_bvalid | stray;
    assign bresp   = stray ? 2'b10 : s_bresp;

    vec_t              cur;
    int                cnt[N_CNT] = '{default: 0};
    string             cnt_name[N_CNT] = '{"ar_hs", "r_hs", "aw_hs", "w_hs", "b_hs",
                                           "arvalid_cycles", "rready_cycles", "awvalid_cycles",
                                           "wvalid_cycles", "bready_cycles"};
    logic [ADDR_W-1:0] cap_araddr = '0;
    logic [ADDR_W-1:0] cap_awaddr = '0;
    logic [DATA_W-1:0] cap_wdata = '0;
    logic [STRB_W-1:0] cap_wstrb = '0;

    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend, aw_got, w_got, r_hs_pend, b_hs_pend;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axi_lite_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    // Slave reacts on the falling edge: ready/valid are raised after the programmed
    // number of waiting cycles; a beat set now completes at the next rising edge.
    always @(negedge aclk) begin
        if (areset) begin
            s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; r_hs_pend = 0; b_hs_pend = 0;
        end else if (slave_en) begin
            if (arvalid) cnt[ARV]++;
            if (rready)  cnt[RRDY]++;
            if (awvalid) cnt[AWV]++;
            if (wvalid)  cnt[WV]++;
            if (bready)  cnt[BRDY]++;

            if (s_arready) begin
                s_arready = 1'b0; r_pend = 1; r_cnt = 0;
            end else if (arvalid) begin
                if (ar_cnt >= cur.ar_d) begin
                    s_arready = 1'b1; ar_cnt = 0; cnt[AR_HS]++; cap_araddr = araddr;
                end else ar_cnt++;
            end

            if (r_hs_pend) begin
                s_rvalid = 1'b0; r_hs_pend = 0;
                s_rdata = {$urandom, $urandom}; s_rresp = 2'($urandom);
            end else if (r_pend) begin
                if (r_cnt >= cur.r_d) begin
                    s_rvalid = 1'b1; s_rdata = cur.slv_rdata; s_rresp = cur.slv_resp; r_pend = 0;
                end else r_cnt++;
            end
            if (s_rvalid && rready) begin
                r_hs_pend = 1; cnt[R_HS]++;
            end

            if (s_awready) begin
                s_awready = 1'b0; aw_got = 1;
            end else if (awvalid) begin
                if (aw_cnt >= cur.aw_d) begin
                    s_awready = 1'b1; aw_cnt = 0; cnt[AW_HS]++; cap_awaddr = awaddr;
                end else aw_cnt++;
            end

            if (s_wready) begin
                s_wready = 1'b0; w_got = 1;
            end else if (wvalid) begin
                if (w_cnt >= cur.w_d) begin
                    s_wready = 1'b1; w_cnt = 0; cnt[W_HS]++; cap_wdata = wdata; cap_wstrb = wstrb;
                end else w_cnt++;
            end

            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_hs_pend) begin
                s_bvalid = 1'b0; b_hs_pend = 0; s_bresp = 2'($urandom);
            end else if (b_pend) begin
                if (b_cnt >= cur.b_d) begin
                    s_bvalid = 1'b1; s_bresp = cur.slv_resp; b_pend = 0;
                end else b_cnt++;
            end
            if (s_bvalid && bready) begin
                b_hs_pend = 1; cnt[B_HS]++;
            end
        end
    end

    function automatic vec_t mkVec(input logic wen, input logic [ADDR_W-1:0] addr,
                                   input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] ws,
                                   input logic [DATA_W-1:0] rd, input logic [1:0] rsp,
                                   input int ar_d, input int r_d, input int aw_d, input int w_d,
                                   input int b_d, input int lat, input logic [DATA_W-1:0] erd,
                                   input logic eerr);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wd; v.wstrb = ws; v.slv_rdata = rd; v.slv_resp = rsp;
        v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
        v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    // Transaction-level expectation: each waiting cycle on a channel adds one
    // cycle; AW and W overlap, so only the slower of the two counts.
    function automatic vec_t refModel(input vec_t v);
        vec_t r;
        r = v;
        r.exp_lat   = v.wen ? ((v.aw_d > v.w_d ? v.aw_d : v.w_d) + v.b_d + 3) : (v.ar_d + v.r_d + 3);
        r.exp_rdata = v.wen ? '0 : v.slv_rdata;
        r.exp_err   = (v.slv_resp != 2'b00);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int  base[N_CNT];
        int  exp_cnt[N_CNT];
        int  k;
        bit  done;
        cur  = v;
        base = cnt;
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        checkOutput({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0; req_wen = ~v.wen; req_addr = $urandom;
        req_wdata = {$urandom, $urandom}; req_wstrb = STRB_W'($urandom);
        k = 1; done = 0;
        while (!done && k < 200) begin
            if (resp_valid) done = 1;
            else begin
                @(negedge aclk);
                k++;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL %s.timeout: got no resp_valid after %0d cycles, expected %0d", tag, k, v.exp_lat);
            doReset();
            return;
        end
        checkOutput({tag, ".latency"}, 64'(k), 64'(v.exp_lat));
        checkOutput({tag, ".resp_rdata"}, resp_rdata, v.exp_rdata);
        checkOutput({tag, ".resp_err"}, 64'(resp_err), 64'(v.exp_err));
        exp_cnt = '{default: 0};
        if (v.wen) begin
            exp_cnt[AW_HS] = 1; exp_cnt[W_HS] = 1; exp_cnt[B_HS] = 1;
            exp_cnt[AWV] = v.aw_d + 1; exp_cnt[WV] = v.w_d + 1; exp_cnt[BRDY] = v.b_d + 1;
            checkOutput({tag, ".awaddr"}, 64'(cap_awaddr), 64'(v.addr));
            checkOutput({tag, ".wdata"}, cap_wdata, v.wdata);
            checkOutput({tag, ".wstrb"}, 64'(cap_wstrb), 64'(v.wstrb));
        end else begin
            exp_cnt[AR_HS] = 1; exp_cnt[R_HS] = 1;
            exp_cnt[ARV] = v.ar_d + 1; exp_cnt[RRDY] = v.r_d + 1;
            checkOutput({tag, ".araddr"}, 64'(cap_araddr), 64'(v.addr));
        end
        for (int i = 0; i < N_CNT; i++) begin
            checkOutput({tag, ".", cnt_name[i]}, 64'(cnt[i] - base[i]), 64'(exp_cnt[i]));
        end
        @(negedge aclk);
        checkOutput({tag, ".resp_pulse_end"}, 64'({resp_valid, req_ready}), 64'(2'b01));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl[6];
        vec_t        v;
        int          base[N_CNT];
        int          k;
        bit          spurious;
        logic [8:1]  exp_rdy;
        logic [8:1]  exp_rsp;

        tbl[0] = mkVec(1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'b00,
                       0, 0, 0, 0, 0, 3, 64'h1122_3344_5566_7788, 1'b0);
        tbl[1] = mkVec(1'b1, 32'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00,
                       0, 0, 0, 2, 0, 5, 64'h0, 1'b0);
        tbl[2] = mkVec(1'b1, 32'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 2'b00,
                       0, 0, 2, 0, 5, 10, 64'h0, 1'b0);
        tbl[3] = mkVec(1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'hCAFE_F00D_1234_5678, 2'b10,
                       0, 0, 0, 0, 0, 3, 64'hCAFE_F00D_1234_5678, 1'b1);
        tbl[4] = mkVec(1'b1, 32'h8000_0030, 64'h1, 8'h01, 64'h0, 2'b01,
                       0, 0, 1, 1, 1, 5, 64'h0, 1'b1);
        tbl[5] = mkVec(1'b0, 32'h8000_0038, 64'h0, 8'h00, 64'h8877_6655_4433_2211, 2'b11,
                       2, 3, 0, 0, 0, 8, 64'h8877_6655_4433_2211, 1'b1);
        cur = tbl[0];

        repeat (3) @(negedge aclk);
        checkOutput("reset.handshake_outputs",
                    64'({arvalid, rready, awvalid, wvalid, bready, resp_valid, req_ready}), 64'(7'b0000001));
        checkOutput("reset.addr_data", 64'({araddr, awaddr}) | wdata | 64'(wstrb), 64'h0);
        checkOutput("reset.resp", resp_rdata | 64'(resp_err), 64'h0);
        areset = 1'b0;
        @(negedge aclk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: req_valid never drops between a read and the following write.
        v = mkVec(1'b0, 32'h8000_0100, 64'h0, 8'h00, 64'hA5A5_0000_1234_5678, 2'b00,
                  0, 0, 0, 0, 0, 3, 64'h0, 1'b0);
        cur = v; base = cnt;
        exp_rdy = 8'b1000_1000;
        exp_rsp = 8'b0100_0100;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0100;
        checkOutput("b2b.req_ready_0", 64'(req_ready), 64'd1);
        @(posedge aclk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge aclk);
            checkOutput($sformatf("b2b.req_ready_%0d", c), 64'(req_ready), 64'(exp_rdy[c]));
            checkOutput($sformatf("b2b.resp_valid_%0d", c), 64'(resp_valid), 64'(exp_rsp[c]));
            if (c == 3) checkOutput("b2b.read_rdata", resp_rdata, 64'hA5A5_0000_1234_5678);
            if (c == 7) checkOutput("b2b.write_rdata", resp_rdata, 64'h0);
            if (c == 1) begin
                req_wen = 1'b1; req_addr = 32'h8000_0200; req_wdata = 64'h0BAD_F00D_0BAD_F00D; req_wstrb = 8'h3C;
            end
            if (c == 5) req_valid = 1'b0;
        end
        checkOutput("b2b.araddr", 64'(cap_araddr), 64'h8000_0100);
        checkOutput("b2b.awaddr", 64'(cap_awaddr), 64'h8000_0200);
        checkOutput("b2b.wdata", cap_wdata, 64'h0BAD_F00D_0BAD_F00D);
        checkOutput("b2b.ar_aw_hs", 64'({16'(cnt[AR_HS] - base[AR_HS]), 16'(cnt[AW_HS] - base[AW_HS])}),
                    64'h0001_0001);

        // Stray R/B beats while idle must not produce a response or ready.
        slave_en = 1'b0; stray = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            checkOutput($sformatf("stray.quiet_%0d", c), 64'({resp_valid, rready, bready, req_ready}), 64'(4'b0001));
        end
        stray = 1'b0; slave_en = 1'b1;
        @(negedge aclk);

        for (int i = 0; i < 40; i++) begin
            v.wen = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            v.wdata = {$urandom, $urandom};
            v.wstrb = STRB_W'($urandom);
            v.slv_rdata = {$urandom, $urandom};
            v.slv_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
            v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
            applyStimulus(refModel(v), $sformatf("rnd%0d", i));
        end

        // Reset while waiting in the B phase drops the transaction silently.
        v = mkVec(1'b1, 32'h8000_0040, 64'h5555_AAAA_5555_AAAA, 8'hF0, 64'h0, 2'b00,
                  0, 0, 0, 0, 20, 0, 64'h0, 1'b0);
        cur = v;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0;
        k = 0;
        while (!bready && k < 20) begin
            @(negedge aclk);
            k++;
        end
        checkOutput("rst.reach_wr_b", 64'(bready), 64'd1);
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst.handshake_outputs",
                    64'({arvalid, rready, awvalid, wvalid, bready, resp_valid, req_ready}), 64'(7'b0000001));
        checkOutput("rst.awaddr", 64'(awaddr), 64'h0);
        @(negedge aclk);
        areset = 1'b0;
        spurious = 0;
        repeat (25) begin
            @(negedge aclk);
            if (resp_valid) spurious = 1;
        end
        checkOutput("rst.no_resp", 64'(spurious), 64'd0);
        applyStimulus(tbl[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
